raiz_iterativa: RTL

Parametrised sequential integer square-root unit, the next generation of the board-level 8-bit square-root datapath. It is generalised to an even operand width N. It computes the floor root and the remainder with the digit-by-digit (bit-pair) method, one result bit per clock. It offers a start/busy/done handshake so a controller or the display top can launch back-to-back operations without re-arming a reset.

---
 rtl/raiz_iterativa.sv | 121 ++++++++++++
 1 files changed

// File: rtl/raiz_iterativa.sv
// Purpose: sequential floor square root plus remainder of an N-bit unsigned radicand, one root bit per clock.
// Latency: exactly N/2 cycles from the accepting edge; back-to-back throughput one result per N/2+1 cycles.
// Backpressure: none; start is taken only when not busy and ignored (never queued) while busy. Optional macro RAIZ_CICLOS_EN adds the ciclos output.
module raiz_iterativa #(
  parameter int N = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     data_in,
  output logic             busy,
  output logic             done,
  output logic [N/2-1:0]   raiz,
  output logic [N/2:0]     resto
`ifdef RAIZ_CICLOS_EN
  ,
  output logic [$clog2(N/2+1)-1:0] ciclos
`endif
);

  localparam int R  = N / 2;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
`ifdef RAIZ_CICLOS_EN
  localparam int CW = $clog2(R + 1);
`endif

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t         estado;
  // Operand is shifted left two bits per iteration so the current bit pair is always its top two bits.
  logic [N-1:0]    op;
  logic [R-1:0]    root;
  logic [R:0]      rem;
  logic [IW-1:0]   idx;
`ifdef RAIZ_CICLOS_EN
  logic [CW-1:0]   cnt;
`endif

  // Trial value, trial divisor and the next partial root/remainder.
  logic [R+2:0]    t;
  logic [R+2:0]    d;
  logic            ge;
  logic [R:0]      rem_nx;
  logic [R-1:0]    root_nx;

  // One digit-by-digit step: bring down the next bit pair and try subtracting 4*root+1.
  always_comb begin
    t       = {rem, op[N-1:N-2]};
    d       = {1'b0, root, 2'b01};
    ge      = (t >= d);
    // The true difference is bounded by 2*root_nx, so the low R+1 bits are exact.
    rem_nx  = ge ? (t[R:0] - d[R:0]) : t[R:0];
    root_nx = (root << 1) | R'(ge);
  end

  // Control FSM and datapath registers; reset wins over any start or iteration on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= OCIOSO;
      busy   <= 1'b0;
      done   <= 1'b0;
      op     <= '0;
      root   <= '0;
      rem    <= '0;
      idx    <= '0;
      raiz   <= '0;
      resto  <= '0;
`ifdef RAIZ_CICLOS_EN
      cnt    <= '0;
      ciclos <= '0;
`endif
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (start) begin
            op     <= data_in;
            root   <= '0;
            rem    <= '0;
            idx    <= IW'(R - 1);
`ifdef RAIZ_CICLOS_EN
            cnt    <= '0;
`endif
            busy   <= 1'b1;
            done   <= 1'b0;
            estado <= CALCULA;
          end
        end
        CALCULA: begin
          op   <= op << 2;
          root <= root_nx;
          rem  <= rem_nx;
          idx  <= idx - 1'b1;
`ifdef RAIZ_CICLOS_EN
          cnt  <= cnt + 1'b1;
`endif
          // Last bit pair: publish results; they stay put until the next completion.
          if (idx == '0) begin
            raiz   <= root_nx;
            resto  <= rem_nx;
`ifdef RAIZ_CICLOS_EN
            ciclos <= cnt + 1'b1;
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            estado <= FIM;
          end
        end
        default: begin
          estado <= OCIOSO;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
